serial_subtractor: RTL

//   Bit-serial two's-complement subtractor, the inverse companion of the 4-bit ripple-carry adder.

---
 rtl/serial_subtractor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per
// clock through a single full-subtractor cell, LSB first. A start/ready/valid
// handshake launches one operation at a time. IDLE -> SHIFT (WIDTH cycles)
// -> DONE (one cycle, valid pulse) -> IDLE.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             valid_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers, borrow chain, partial result and bit counter.
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Operand sign bits captured at accept, used for signed overflow.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;

  // Visible results; they change only when the operation completes.
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell operating on the current LSBs.
  logic x_bit, y_bit;
  logic d_bit;
  logic borrow_nxt;
  logic last_bit;

  assign x_bit      = a_sh_q[0];
  assign y_bit      = b_sh_q[0];
  assign d_bit      = x_bit ^ y_bit ^ borrow_q;
  assign borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);
  assign last_bit   = (cnt_q == LAST_BIT);

  // State register.
  // NOTE: clocked processes use non-blocking (<=) so every register samples
  // the pre-edge values of its peers; blocking (=) would create order-dependent
  // races between processes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept only in IDLE, walk WIDTH bits, one DONE cycle.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i)  state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    ready_o = (state_q == S_IDLE);
    valid_o = (state_q == S_DONE);
  end

  // Datapath next-state: load on accept, shift one bit per SHIFT cycle,
  // publish diff/bout/ovf on the transition into DONE.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sh_d   = a_i;
          b_sh_d   = b_i;
          borrow_d = bin_i;
          cnt_d    = '0;
          a_msb_d  = a_i[WIDTH-1];
          b_msb_d  = b_i[WIDTH-1];
        end
      end
      S_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = borrow_nxt;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        if (last_bit) begin
          cnt_d  = '0;
          diff_d = {d_bit, res_q[WIDTH-1:1]};
          bout_d = borrow_nxt;
          // d_bit is the result MSB here; overflow only when operand signs
          // differ and the result sign departs from the minuend sign.
          ovf_d  = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears shift state and visible results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff_o = diff_q;
  assign bout_o = bout_q;
  assign ovf_o  = ovf_q;

endmodule
